// File: rtl/ahb_slave_sram.sv
// AHB responder in front of a word-addressed on-chip SRAM: registers the address
// phase, inserts programmable wait states and answers bad or retried accesses in two cycles.
module ahb_slave_sram #(
   parameter int BUS_WDT     = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic               i_hclk,
   input  logic               i_hreset,
   input  logic               i_hsel,
   input  logic               i_hready,
   input  logic [31:0]        i_haddr,
   input  logic [1:0]         i_htrans,
   input  logic [1:0]         i_hsize,
   input  logic               i_hwrite,
   input  logic [BUS_WDT-1:0] i_hwdata,
   input  logic               i_retry_en,
   output logic               o_hready,
   output logic [1:0]         o_hresp,
   output logic [BUS_WDT-1:0] o_hrdata
);

   localparam int NBYTES = BUS_WDT / 8;
   localparam int BL     = $clog2(NBYTES);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_LAST = 3'd2;
   localparam logic [2:0] S_ERR1 = 3'd3;
   localparam logic [2:0] S_ERR2 = 3'd4;

   localparam logic [1:0] RESP_OKAY  = 2'd0;
   localparam logic [1:0] RESP_ERROR = 2'd1;
   localparam logic [1:0] RESP_RETRY = 2'd2;

   logic [2:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] word_q, word_d;
   logic [BL-1:0]         off_q, off_d;
   logic [1:0]            size_q, size_d;
   logic                  write_q, write_d;
   logic [1:0]            resp_q, resp_d;

   logic [BUS_WDT-1:0]    mem [2**DEPTH_LOG2];

   logic                  accept;
   logic [1:0]            respClass;
   logic [NBYTES-1:0]     laneEn;
   logic                  doWrite;

   assign accept = i_hsel && i_hready && (i_htrans == 2'b10 || i_htrans == 2'b11);

   // Response class decided once at accept; retry wins over every decode error
   always_comb begin
      respClass = RESP_OKAY;
      if (i_retry_en) begin
         respClass = RESP_RETRY;
      end else if (int'(i_hsize) > BL) begin
         respClass = RESP_ERROR;
      end else if ((i_haddr & ((32'd1 << i_hsize) - 32'd1)) != 32'd0) begin
         respClass = RESP_ERROR;
      end else if ((i_haddr >> (BL + DEPTH_LOG2)) != 32'd0) begin
         respClass = RESP_ERROR;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      off_d   = off_q;
      size_d  = size_q;
      write_d = write_q;
      resp_d  = resp_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_LAST;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ERR1: state_d = S_ERR2;
         // Every hready-high state may take the next address phase
         default: begin
            state_d = S_IDLE;
            if (accept) begin
               word_d  = i_haddr[BL +: DEPTH_LOG2];
               off_d   = i_haddr[BL-1:0];
               size_d  = i_hsize;
               write_d = i_hwrite;
               resp_d  = respClass;
               if (respClass != RESP_OKAY) begin
                  state_d = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = S_LAST;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         off_q   <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         resp_q  <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         off_q   <= off_d;
         size_q  <= size_d;
         write_q <= write_d;
         resp_q  <= resp_d;
      end
   end

   always_comb begin
      laneEn = '0;
      for (int b = 0; b < NBYTES; b++) begin
         laneEn[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
      end
   end

   // A reset on the completing edge abandons the write
   assign doWrite = (state_q == S_LAST) && write_q && !i_hreset;

   always_ff @(posedge i_hclk) begin
      if (doWrite) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (laneEn[b]) begin
               mem[word_q][8*b +: 8] <= i_hwdata[8*b +: 8];
            end
         end
      end
   end

   assign o_hready = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
   assign o_hresp  = (state_q == S_ERR1 || state_q == S_ERR2) ? resp_q : RESP_OKAY;
   assign o_hrdata = (state_q == S_LAST && !write_q) ? mem[word_q] : '0;

endmodule
